// File: rtl/stream_fifo_pkg.sv
// Shared helpers for the SRAM-backed stream FIFO: the width calculations and
// the wrap-around pointer increment used by the read and write pointers.
package stream_fifo_pkg;

    // Source of the head word presented on r_data_o
    typedef enum logic {
        SRC_SRAM   = 1'b0,
        SRC_BYPASS = 1'b1
    } rdSrc_e;

    // Pointer width; depth is always at least 2, so this is never zero
    function automatic int unsigned calcAddrWidth(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Count width must be able to hold the value "depth" itself
    function automatic int unsigned calcCntWidth(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Increment that wraps at depth-1, so non-power-of-two depths work
    function automatic int unsigned wrapInc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/dualportSRAM.sv
// Simple dual-port SRAM macro: one write port with byte enables, one read
// port with a registered output (data appears one cycle after the address).
module dualportSRAM #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned BEW       = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [BEW-1:0]        wbe_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Byte-masked write into the array
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < int'(DATA_WIDTH); i++) begin
                if (wbe_i[i / 8]) begin
                    mem_q[waddr_i][i] <= wdata_i[i];
                end
            end
        end
    end

    // Registered read; output holds its value when the read is not enabled
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/stream_fifo_wrap_ptr.sv
// Wrapping FIFO pointer: counts 0..DEPTH-1 then returns to 0. Also exposes
// the next value so the read side can prefetch the following entry.
module stream_fifo_wrap_ptr
    import stream_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = calcAddrWidth(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o,
    output logic [AW-1:0] ptrNext_o
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    assign ptrNext_o = AW'(wrapInc(32'(ptr_q), DEPTH));
    assign ptr_o     = ptr_q;

    // Next pointer: flush returns to the start, otherwise step on enable
    always_comb begin
        ptr_d = ptr_q;
        if (flush_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptrNext_o;
        end
    end

    // Pointer register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stream_fifo_sram_v2.sv
// SRAM-backed stream FIFO with first-word-fall-through output, arbitrary
// depth, write/read occupancy counts and synchronous flush.
// Define STREAM_FIFO_SRAM_WATERMARK_EN to add registered almost-full and
// almost-empty flags.
module stream_fifo_sram_v2
    import stream_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int unsigned AE_LEVEL   = 1,
    localparam int unsigned ADDR_WIDTH = calcAddrWidth(FIFO_DEPTH),
    localparam int unsigned CNT_WIDTH  = calcCntWidth(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    input  logic [DATA_WIDTH-1:0] w_data_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [CNT_WIDTH-1:0]  w_count_o,
    output logic [CNT_WIDTH-1:0]  r_count_o
`ifdef STREAM_FIFO_SRAM_WATERMARK_EN
    ,
    output logic                  almost_full_o,
    output logic                  almost_empty_o
`endif
);

    localparam int unsigned BE_WIDTH = (DATA_WIDTH + 7) / 8;

    logic                  push;
    logic                  pop;
    logic                  collide;
    logic [ADDR_WIDTH-1:0] wrPtr;
    logic [ADDR_WIDTH-1:0] wrPtrNext;
    logic [ADDR_WIDTH-1:0] rdPtr;
    logic [ADDR_WIDTH-1:0] rdPtrNext;
    logic [ADDR_WIDTH-1:0] rdAddr;
    logic [DATA_WIDTH-1:0] sramQ;

    logic [CNT_WIDTH-1:0]  wCount_q, wCount_d;
    logic [CNT_WIDTH-1:0]  rCount_q, rCount_d;
    logic                  pushPend_q, pushPend_d;
    logic [DATA_WIDTH-1:0] bypassData_q, bypassData_d;
    rdSrc_e                rdSrc_q, rdSrc_d;

    assign w_ready_o = (wCount_q < CNT_WIDTH'(FIFO_DEPTH)) & ~flush_i;
    assign r_valid_o = (rCount_q != '0);
    assign push      = w_valid_i & w_ready_o;
    assign pop       = r_valid_o & r_ready_i;
    assign w_count_o = wCount_q;
    assign r_count_o = rCount_q;

    stream_fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH)) u_wrPtr (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_i),
        .inc_i     (push),
        .ptr_o     (wrPtr),
        .ptrNext_o (wrPtrNext)
    );

    stream_fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH)) u_rdPtr (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_i),
        .inc_i     (pop),
        .ptr_o     (rdPtr),
        .ptrNext_o (rdPtrNext)
    );

    // Prefetch: look at the entry that will be the head after this cycle.
    // A write to that same slot skips the SRAM read and uses the bypass.
    assign rdAddr  = pop ? rdPtrNext : rdPtr;
    assign collide = push & (wrPtr == rdAddr);

    dualportSRAM #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_sram (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wrPtr),
        .wdata_i (w_data_i),
        .wbe_i   ({BE_WIDTH{1'b1}}),
        .re_i    (~collide),
        .raddr_i (rdAddr),
        .rdata_o (sramQ)
    );

    // Occupancy: the read count lags the write count by the last push only
    always_comb begin
        wCount_d   = wCount_q;
        rCount_d   = rCount_q;
        pushPend_d = push;
        case ({push, pop})
            2'b10:   wCount_d = wCount_q + 1'b1;
            2'b01:   wCount_d = wCount_q - 1'b1;
            default: wCount_d = wCount_q;
        endcase
        case ({pushPend_q, pop})
            2'b10:   rCount_d = rCount_q + 1'b1;
            2'b01:   rCount_d = rCount_q - 1'b1;
            default: rCount_d = rCount_q;
        endcase
        if (flush_i) begin
            wCount_d   = '0;
            rCount_d   = '0;
            pushPend_d = 1'b0;
        end
    end

    // Count registers; reset wins over flush
    always_ff @(posedge clk) begin
        if (rst) begin
            wCount_q   <= '0;
            rCount_q   <= '0;
            pushPend_q <= 1'b0;
        end else begin
            wCount_q   <= wCount_d;
            rCount_q   <= rCount_d;
            pushPend_q <= pushPend_d;
        end
    end

    // Capture colliding write data and choose which source drives the head
    always_comb begin
        bypassData_d = bypassData_q;
        rdSrc_d      = SRC_SRAM;
        if (collide) begin
            bypassData_d = w_data_i;
            rdSrc_d      = SRC_BYPASS;
        end
    end

    // Bypass registers; reset selects the zeroed bypass so r_data_o reads 0
    always_ff @(posedge clk) begin
        if (rst) begin
            bypassData_q <= '0;
            rdSrc_q      <= SRC_BYPASS;
        end else begin
            bypassData_q <= bypassData_d;
            rdSrc_q      <= rdSrc_d;
        end
    end

    assign r_data_o = (rdSrc_q == SRC_BYPASS) ? bypassData_q : sramQ;

`ifdef STREAM_FIFO_SRAM_WATERMARK_EN
    logic afFlag_q;
    logic aeFlag_q;

    // Watermark flags follow the counts one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            afFlag_q <= 1'b0;
            aeFlag_q <= 1'b1;
        end else begin
            afFlag_q <= (wCount_q >= CNT_WIDTH'(AF_LEVEL));
            aeFlag_q <= (rCount_q <= CNT_WIDTH'(AE_LEVEL));
        end
    end

    assign almost_full_o  = afFlag_q;
    assign almost_empty_o = aeFlag_q;
`else
    // No watermark flags in this build; the thresholds have no effect
`endif

endmodule

// File: tb/tb_stream_fifo_sram_v2.sv
// Directed self-checking bench for stream_fifo_sram_v2 at depth 5.
// Watermark checks are included when STREAM_FIFO_SRAM_WATERMARK_EN is defined.
module tb_stream_fifo_sram_v2;

    logic        clk;
    logic        rst;
    logic        flushIn;
    logic        wValid;
    logic        wReady;
    logic [31:0] wData;
    logic        rValid;
    logic        rReady;
    logic [31:0] rData;
    logic [2:0]  wCount;
    logic [2:0]  rCount;
`ifdef STREAM_FIFO_SRAM_WATERMARK_EN
    logic        almostFull;
    logic        almostEmpty;
`endif

    int checksTotal  = 0;
    int checksPassed = 0;

    stream_fifo_sram_v2 #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (5),
        .AF_LEVEL   (4),
        .AE_LEVEL   (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flushIn),
        .w_valid_i      (wValid),
        .w_ready_o      (wReady),
        .w_data_i       (wData),
        .r_valid_o      (rValid),
        .r_ready_i      (rReady),
        .r_data_o       (rData),
        .w_count_o      (wCount),
        .r_count_o      (rCount)
`ifdef STREAM_FIFO_SRAM_WATERMARK_EN
        ,
        .almost_full_o  (almostFull),
        .almost_empty_o (almostEmpty)
`endif
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one active edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the write/read handshake inputs
    task automatic applyStimulus(input logic wv, input logic [31:0] wd, input logic rr);
        wValid = wv;
        wData  = wd;
        rReady = rr;
    endtask

    task automatic resetDut();
        rst     = 1'b1;
        flushIn = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        resetDut();
        checksTotal++;
        if (wReady !== 1'b1) $display("[TB] FAIL reset_w_ready: got %0b expected 1", wReady);
        else checksPassed++;
        checksTotal++;
        if (rValid !== 1'b0) $display("[TB] FAIL reset_r_valid: got %0b expected 0", rValid);
        else checksPassed++;
        checksTotal++;
        if (wCount !== 3'd0 || rCount !== 3'd0) $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", wCount, rCount);
        else checksPassed++;
        checksTotal++;
        if (rData !== 32'h0) $display("[TB] FAIL reset_r_data: got %h expected 00000000", rData);
        else checksPassed++;
`ifdef STREAM_FIFO_SRAM_WATERMARK_EN
        checksTotal++;
        if (almostFull !== 1'b0 || almostEmpty !== 1'b1) $display("[TB] FAIL reset_flags: got af=%0b ae=%0b expected af=0 ae=1", almostFull, almostEmpty);
        else checksPassed++;
`endif
    endtask

    task automatic test_fill();
        resetDut();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'hA0 + 32'(i), 1'b0);
            step();
        end
        checksTotal++;
        if (wCount !== 3'd5) $display("[TB] FAIL fill_w_count: got %0d expected 5", wCount);
        else checksPassed++;
        checksTotal++;
        if (wReady !== 1'b0) $display("[TB] FAIL fill_w_ready: got %0b expected 0", wReady);
        else checksPassed++;
        checksTotal++;
        if (rCount !== 3'd4) $display("[TB] FAIL fill_r_count_lag: got %0d expected 4", rCount);
        else checksPassed++;
        applyStimulus(1'b1, 32'hA5, 1'b0);
        step();
        checksTotal++;
        if (wCount !== 3'd5 || rCount !== 3'd5) $display("[TB] FAIL fill_sixth_write: got %0d/%0d expected 5/5", wCount, rCount);
        else checksPassed++;
        checksTotal++;
        if (rValid !== 1'b1 || rData !== 32'hA0) $display("[TB] FAIL fill_head: got v=%0b d=%h expected v=1 d=000000a0", rValid, rData);
        else checksPassed++;
        applyStimulus(1'b0, 32'h0, 1'b0);
        step();
        checksTotal++;
        if (rData !== 32'hA0) $display("[TB] FAIL fill_head_stable: got %h expected 000000a0", rData);
        else checksPassed++;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checksTotal++;
            if (rValid !== 1'b1 || rData !== 32'hA0 + 32'(i)) $display("[TB] FAIL fill_drain_%0d: got v=%0b d=%h expected v=1 d=%h", i, rValid, rData, 32'hA0 + 32'(i));
            else checksPassed++;
            step();
            if (i == 0) begin
                checksTotal++;
                if (wReady !== 1'b1) $display("[TB] FAIL fill_ready_after_pop: got %0b expected 1", wReady);
                else checksPassed++;
            end
        end
        checksTotal++;
        if (rValid !== 1'b0 || wCount !== 3'd0) $display("[TB] FAIL fill_empty_after_drain: got v=%0b cnt=%0d expected v=0 cnt=0", rValid, wCount);
        else checksPassed++;
        applyStimulus(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] expQ[$];
        int          cnt;
        int          nextVal;
        logic        accept;
        resetDut();
        nextVal = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(nextVal), 1'b0);
            expQ.push_back(32'h100 + 32'(nextVal));
            nextVal++;
            step();
        end
        cnt = 5;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b1, 32'h100 + 32'(nextVal), 1'b1);
            checksTotal++;
            if (rValid !== 1'b1 || rData !== expQ[0]) $display("[TB] FAIL b2b_cycle_%0d: got v=%0b d=%h expected v=1 d=%h", c, rValid, rData, expQ[0]);
            else checksPassed++;
            accept = (cnt < 5);
            checksTotal++;
            if (wReady !== accept || wCount !== 3'(cnt)) $display("[TB] FAIL b2b_wside_%0d: got rdy=%0b cnt=%0d expected rdy=%0b cnt=%0d", c, wReady, wCount, accept, cnt);
            else checksPassed++;
            void'(expQ.pop_front());
            if (accept) begin
                expQ.push_back(32'h100 + 32'(nextVal));
                nextVal++;
            end
            cnt = cnt - 1 + (accept ? 1 : 0);
            step();
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        while (expQ.size() > 0) begin
            checksTotal++;
            if (rValid !== 1'b1 || rData !== expQ[0]) $display("[TB] FAIL b2b_drain: got v=%0b d=%h expected v=1 d=%h", rValid, rData, expQ[0]);
            else checksPassed++;
            void'(expQ.pop_front());
            step();
        end
        checksTotal++;
        if (rValid !== 1'b0 || wCount !== 3'd0 || rCount !== 3'd0) $display("[TB] FAIL b2b_final_empty: got v=%0b cnt=%0d/%0d expected v=0 cnt=0/0", rValid, wCount, rCount);
        else checksPassed++;
        applyStimulus(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_bypass();
        resetDut();
        applyStimulus(1'b1, 32'h55, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b1);
        checksTotal++;
        if (rValid !== 1'b0 || wCount !== 3'd1) $display("[TB] FAIL bypass_pending: got v=%0b cnt=%0d expected v=0 cnt=1", rValid, wCount);
        else checksPassed++;
        step();
        checksTotal++;
        if (rValid !== 1'b1 || rData !== 32'h55) $display("[TB] FAIL bypass_visible: got v=%0b d=%h expected v=1 d=00000055", rValid, rData);
        else checksPassed++;
        step();
        checksTotal++;
        if (rValid !== 1'b0 || wCount !== 3'd0) $display("[TB] FAIL bypass_popped: got v=%0b cnt=%0d expected v=0 cnt=0", rValid, wCount);
        else checksPassed++;
        applyStimulus(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_flush();
        resetDut();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'hC0 + 32'(i), 1'b0);
            step();
        end
        applyStimulus(1'b1, 32'hC3, 1'b0);
        flushIn = 1'b1;
        #1;
        checksTotal++;
        if (wReady !== 1'b0) $display("[TB] FAIL flush_blocks_push: got %0b expected 0", wReady);
        else checksPassed++;
        step();
        flushIn = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0);
        #1;
        checksTotal++;
        if (wCount !== 3'd0 || rCount !== 3'd0) $display("[TB] FAIL flush_counts: got %0d/%0d expected 0/0", wCount, rCount);
        else checksPassed++;
        checksTotal++;
        if (rValid !== 1'b0 || wReady !== 1'b1) $display("[TB] FAIL flush_flags: got v=%0b rdy=%0b expected v=0 rdy=1", rValid, wReady);
        else checksPassed++;
        applyStimulus(1'b1, 32'h77, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0);
        step();
        checksTotal++;
        if (rValid !== 1'b1 || rData !== 32'h77) $display("[TB] FAIL flush_readback: got v=%0b d=%h expected v=1 d=00000077", rValid, rData);
        else checksPassed++;
    endtask

    task automatic test_midstream_reset();
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'hD0 + 32'(i), 1'b0);
            step();
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        step();
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        step();
        rst = 1'b0;
        #1;
        checksTotal++;
        if (wReady !== 1'b1 || rValid !== 1'b0) $display("[TB] FAIL rst_mid_handshake: got rdy=%0b v=%0b expected rdy=1 v=0", wReady, rValid);
        else checksPassed++;
        checksTotal++;
        if (wCount !== 3'd0 || rCount !== 3'd0) $display("[TB] FAIL rst_mid_counts: got %0d/%0d expected 0/0", wCount, rCount);
        else checksPassed++;
        checksTotal++;
        if (rData !== 32'h0) $display("[TB] FAIL rst_mid_data: got %h expected 00000000", rData);
        else checksPassed++;
        step();
        step();
        checksTotal++;
        if (rValid !== 1'b0) $display("[TB] FAIL rst_mid_no_stale: got %0b expected 0", rValid);
        else checksPassed++;
        applyStimulus(1'b1, 32'hE1, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0);
        step();
        checksTotal++;
        if (rValid !== 1'b1 || rData !== 32'hE1 || rCount !== 3'd1) $display("[TB] FAIL rst_mid_readback: got v=%0b d=%h cnt=%0d expected v=1 d=000000e1 cnt=1", rValid, rData, rCount);
        else checksPassed++;
    endtask

`ifdef STREAM_FIFO_SRAM_WATERMARK_EN
    task automatic test_watermark();
        logic expAe;
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'hF0 + 32'(i), 1'b0);
            step();
            expAe = (i < 3);
            checksTotal++;
            if (almostFull !== 1'b0 || almostEmpty !== expAe) $display("[TB] FAIL wm_push_%0d: got af=%0b ae=%0b expected af=0 ae=%0b", i, almostFull, almostEmpty, expAe);
            else checksPassed++;
        end
        applyStimulus(1'b0, 32'h0, 1'b0);
        step();
        checksTotal++;
        if (almostFull !== 1'b1 || almostEmpty !== 1'b0) $display("[TB] FAIL wm_settled: got af=%0b ae=%0b expected af=1 ae=0", almostFull, almostEmpty);
        else checksPassed++;
    endtask
`endif

    // Run every scenario in order, then report
    initial begin
        $display("[TB] starting stream_fifo_sram_v2 bench");
        test_reset();
        test_fill();
        test_back_to_back();
        test_bypass();
        test_flush();
        test_midstream_reset();
`ifdef STREAM_FIFO_SRAM_WATERMARK_EN
        test_watermark();
`endif
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
